// File: rtl/branch_resolve_unit_if.sv
// Fetch/decode/execute signal bundle for the branch resolve unit.
// The slave modport is the unit itself; master is whoever drives the pipeline side.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      PC_IF;
  logic             found_IF;
  logic [31:0]      NPC_predicted_IF;
  logic             stall_ID;
  logic             stall_EX;
  logic             flush_ID;
  logic             flush_EX;
  logic [2:0]       branch_EX;
  logic             br_EX;
  logic [31:0]      branch_target_EX;
  logic             found_EX;
  logic             pred_taken_EX;
  logic [31:0]      pred_target_EX;
  logic [31:0]      PC_EX;
  logic             mispredict;
  logic [31:0]      redirect_PC;
  logic             update_en;
  logic [31:0]      update_PC;
  logic [31:0]      update_target;
  logic             update_taken;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport slave (
    input  PC_IF, found_IF, NPC_predicted_IF, stall_ID, stall_EX, flush_ID, flush_EX,
           branch_EX, br_EX, branch_target_EX,
    output found_EX, pred_taken_EX, pred_target_EX, PC_EX, mispredict, redirect_PC,
           update_en, update_PC, update_target, update_taken, branch_cnt, mispredict_cnt
  );

  modport master (
    output PC_IF, found_IF, NPC_predicted_IF, stall_ID, stall_EX, flush_ID, flush_EX,
           branch_EX, br_EX, branch_target_EX,
    input  found_EX, pred_taken_EX, pred_target_EX, PC_EX, mispredict, redirect_PC,
           update_en, update_PC, update_target, update_taken, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Carries branch-prediction metadata from IF to EX, resolves mispredicts in EX,
// issues predictor updates and keeps saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int         CNT_W    = 32,
  parameter logic [2:0] NOBRANCH = 3'd0   // the pipeline's "not a branch" branch_EX code
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);

  logic             r_first;
  logic             r_valid_p1, r_found_p1, r_pt_p1;
  logic [31:0]      r_pc_p1, r_tgt_p1;
  logic             r_valid_p2, r_found_p2, r_pt_p2;
  logic [31:0]      r_pc_p2, r_tgt_p2;
  logic [CNT_W-1:0] r_bcnt, r_mcnt;

  logic             w_pred_taken_if;
  logic             w_adv;
  logic             w_is_br;
  logic             w_mispredict;
  logic             w_update_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A fall-through prediction is not "taken", even on a predictor hit.
  assign w_pred_taken_if = bus.found_IF && (bus.NPC_predicted_IF != (bus.PC_IF + 32'd4));

  assign w_adv        = r_valid_p2 && !bus.stall_EX;
  assign w_is_br      = (bus.branch_EX != NOBRANCH);
  assign w_mispredict = !rst && w_adv &&
                        ((bus.br_EX ^ r_pt_p2) ||
                         (bus.br_EX && r_pt_p2 && (bus.branch_target_EX != r_tgt_p2)));
  assign w_update_en  = !rst && w_adv && (w_is_br || r_found_p2);

  // IF -> ID/EX metadata; r_first keeps the first post-reset edge idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first    <= 1'b1;
      r_valid_p1 <= 1'b0;
      r_found_p1 <= 1'b0;
      r_pt_p1    <= 1'b0;
      r_pc_p1    <= '0;
      r_tgt_p1   <= '0;
      r_valid_p2 <= 1'b0;
      r_found_p2 <= 1'b0;
      r_pt_p2    <= 1'b0;
      r_pc_p2    <= '0;
      r_tgt_p2   <= '0;
    end else if (r_first) begin
      r_first <= 1'b0;
    end else begin
      if (w_mispredict || bus.flush_ID) r_valid_p1 <= 1'b0;
      else if (!bus.stall_ID)           r_valid_p1 <= 1'b1;
      if (!bus.stall_ID) begin
        r_pc_p1    <= bus.PC_IF;
        r_found_p1 <= bus.found_IF;
        r_pt_p1    <= w_pred_taken_if;
        r_tgt_p1   <= bus.NPC_predicted_IF;
      end
      // ID -> EX
      if (w_mispredict || bus.flush_EX) r_valid_p2 <= 1'b0;
      else if (!bus.stall_EX)           r_valid_p2 <= r_valid_p1;
      if (!bus.stall_EX) begin
        r_pc_p2    <= r_pc_p1;
        r_found_p2 <= r_found_p1;
        r_pt_p2    <= r_pt_p1;
        r_tgt_p2   <= r_tgt_p1;
      end
    end
  end

  // Performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt <= '0;
      r_mcnt <= '0;
    end else begin
      if (w_adv && w_is_br) r_bcnt <= sat_inc(r_bcnt);
      if (w_mispredict)     r_mcnt <= sat_inc(r_mcnt);
    end
  end

  assign bus.found_EX       = r_found_p2;
  assign bus.pred_taken_EX  = r_pt_p2;
  assign bus.pred_target_EX = r_tgt_p2;
  assign bus.PC_EX          = r_pc_p2;
  assign bus.mispredict     = w_mispredict;
  assign bus.redirect_PC    = bus.br_EX ? bus.branch_target_EX : (r_pc_p2 + 32'd4);
  assign bus.update_en      = w_update_en;
  assign bus.update_PC      = r_pc_p2;
  assign bus.update_taken   = bus.br_EX && w_is_br;
  assign bus.update_target  = bus.br_EX ? bus.branch_target_EX : r_tgt_p2;
  assign bus.branch_cnt     = r_bcnt;
  assign bus.mispredict_cnt = r_mcnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_branch_resolve_unit;
  localparam int         CNT_W = 4;
  localparam int         CMAX  = (1 << CNT_W) - 1;
  localparam logic [2:0] NOBR  = 3'd0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.CNT_W(CNT_W)) bif ();
  branch_resolve_unit #(.CNT_W(CNT_W), .NOBRANCH(NOBR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        f;
    logic        pt;
    logic [31:0] tgt;
  } meta_t;

  meta_t m_id, m_ex;
  int    m_bcnt, m_mcnt;
  bit    m_first;
  int    errs = 0;
  int    checks = 0;

  logic        e_misp, e_upd, e_adv, e_isbr;
  logic [31:0] e_redir, e_utgt;
  logic        e_utaken;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_id    = '{v: 1'b0, pc: '0, f: 1'b0, pt: 1'b0, tgt: '0};
    m_ex    = m_id;
    m_bcnt  = 0;
    m_mcnt  = 0;
    m_first = 1'b1;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic void model_eval();
    e_adv    = m_ex.v && !bif.stall_EX;
    e_isbr   = (bif.branch_EX != NOBR);
    // Wrong path: taken-ness disagrees, or both taken to different places.
    e_misp   = !rst && e_adv && ((bif.br_EX != m_ex.pt) ||
                                 (bif.br_EX && bif.branch_target_EX != m_ex.tgt));
    e_redir  = bif.br_EX ? bif.branch_target_EX : m_ex.pc + 32'd4;
    e_upd    = !rst && e_adv && (e_isbr || m_ex.f);
    e_utaken = bif.br_EX && e_isbr;
    e_utgt   = bif.br_EX ? bif.branch_target_EX : m_ex.tgt;
  endfunction

  task automatic compare();
    model_eval();
    chk("found_EX",       {31'd0, bif.found_EX},      {31'd0, m_ex.f});
    chk("pred_taken_EX",  {31'd0, bif.pred_taken_EX}, {31'd0, m_ex.pt});
    chk("pred_target_EX", bif.pred_target_EX,         m_ex.tgt);
    chk("PC_EX",          bif.PC_EX,                  m_ex.pc);
    chk("mispredict",     {31'd0, bif.mispredict},    {31'd0, e_misp});
    chk("update_en",      {31'd0, bif.update_en},     {31'd0, e_upd});
    chk("branch_cnt",     32'(bif.branch_cnt),        32'(m_bcnt));
    chk("mispredict_cnt", 32'(bif.mispredict_cnt),    32'(m_mcnt));
    if (e_misp) chk("redirect_PC", bif.redirect_PC, e_redir);
    if (e_upd) begin
      chk("update_PC",     bif.update_PC,                m_ex.pc);
      chk("update_taken",  {31'd0, bif.update_taken},    {31'd0, e_utaken});
      chk("update_target", bif.update_target,            e_utgt);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    if (rst) model_reset();
    compare();
  endtask

  task automatic advance();
    meta_t       n_id, n_ex;
    logic [31:0] seq;
    model_eval();
    if (rst) begin
      @(posedge clk);
      #1 model_reset();
      return;
    end
    n_id = m_id;
    n_ex = m_ex;
    if (!m_first) begin
      seq = bif.PC_IF + 32'd4;
      if (!bif.stall_ID)
        n_id = '{v: 1'b1, pc: bif.PC_IF, f: bif.found_IF,
                 pt: bif.found_IF && (bif.NPC_predicted_IF != seq), tgt: bif.NPC_predicted_IF};
      if (bif.flush_ID || e_misp) n_id.v = 1'b0;
      if (!bif.stall_EX) n_ex = m_id;
      if (bif.flush_EX || e_misp) n_ex.v = 1'b0;
      if (e_adv && e_isbr) m_bcnt = sat(m_bcnt);
      if (e_misp)          m_mcnt = sat(m_mcnt);
    end
    @(posedge clk);
    #1;
    m_first = 1'b0;
    m_id = n_id;
    m_ex = n_ex;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic drive(input logic [31:0] pc, input logic f, input logic [31:0] npc,
                       input logic sid, input logic sex, input logic fid, input logic fex,
                       input logic [2:0] bt, input logic br, input logic [31:0] tgt);
    bif.PC_IF            = pc;
    bif.found_IF         = f;
    bif.NPC_predicted_IF = npc;
    bif.stall_ID         = sid;
    bif.stall_EX         = sex;
    bif.flush_ID         = fid;
    bif.flush_EX         = fex;
    bif.branch_EX        = bt;
    bif.br_EX            = br;
    bif.branch_target_EX = tgt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  nmisp;
    bit  hit;
    logic [31:0] pc, npc, tgt;

    rst = 1'b1;
    drive(32'h0, 0, 32'h0, 0, 0, 0, 0, NOBR, 0, 32'h0);
    model_reset();
    cycle();
    chk("reset_branch_cnt", 32'(bif.branch_cnt), 32'd0);
    chk("reset_PC_EX",      bif.PC_EX,           32'd0);
    cycle();
    rst = 1'b0;
    drive(32'h10, 1, 32'h80, 0, 0, 0, 0, NOBR, 0, 32'h0);
    cycle();                                   // first edge after reset stays idle
    drive(32'h20, 0, 32'h0, 0, 0, 0, 0, NOBR, 0, 32'h0);
    cycle();
    chk("post_reset_PC_EX", bif.PC_EX, 32'd0);

    // Predicted-taken hit resolves correctly
    drive(32'h100, 1, 32'h140, 0, 0, 0, 0, NOBR, 0, 32'h0);
    cycle();
    drive(32'h104, 0, 32'h0, 0, 0, 0, 0, NOBR, 0, 32'h0);
    cycle();
    drive(32'h108, 0, 32'h0, 0, 0, 0, 0, 3'd1, 1, 32'h140);
    settle();
    chk("hit_PC_EX",        bif.PC_EX,                   32'h100);
    chk("hit_mispredict",   {31'd0, bif.mispredict},     32'd0);
    chk("hit_update_en",    {31'd0, bif.update_en},      32'd1);
    chk("hit_update_taken", {31'd0, bif.update_taken},   32'd1);
    advance();
    chk("hit_branch_cnt",   32'(bif.branch_cnt),         32'd1);

    // Predictor miss, branch taken
    drive(32'h200, 0, 32'h0, 0, 0, 0, 0, NOBR, 0, 32'h0);
    cycle();
    drive(32'h204, 0, 32'h0, 0, 0, 0, 0, NOBR, 0, 32'h0);
    cycle();
    drive(32'h208, 0, 32'h0, 0, 0, 0, 0, 3'd1, 1, 32'h080);
    settle();
    chk("miss_mispredict",  {31'd0, bif.mispredict},     32'd1);
    chk("miss_redirect",    bif.redirect_PC,             32'h080);
    advance();
    chk("miss_mcnt",        32'(bif.mispredict_cnt),     32'd1);
    drive(32'h080, 0, 32'h0, 0, 0, 0, 0, 3'd1, 1, 32'h500);
    settle();
    chk("flushed_ex_mispredict", {31'd0, bif.mispredict}, 32'd0);
    chk("flushed_ex_update_en",  {31'd0, bif.update_en},  32'd0);
    advance();

    // Predicted taken, actually not taken
    drive(32'h300, 1, 32'h340, 0, 0, 0, 0, NOBR, 0, 32'h0);
    cycle();
    drive(32'h304, 0, 32'h0, 0, 0, 0, 0, NOBR, 0, 32'h0);
    cycle();
    drive(32'h308, 0, 32'h0, 0, 0, 0, 0, 3'd2, 0, 32'h999);
    settle();
    chk("nt_mispredict",    {31'd0, bif.mispredict},     32'd1);
    chk("nt_redirect",      bif.redirect_PC,             32'h304);
    chk("nt_update_taken",  {31'd0, bif.update_taken},   32'd0);
    chk("nt_update_target", bif.update_target,           32'h340);
    advance();

    // Mispredicting instruction held in EX by a stall
    drive(32'h400, 0, 32'h0, 0, 0, 0, 0, NOBR, 0, 32'h0);
    cycle();
    drive(32'h404, 0, 32'h0, 0, 0, 0, 0, NOBR, 0, 32'h0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(32'h408, 0, 32'h0, 0, 1, 0, 0, 3'd1, 1, 32'h040);
      settle();
      chk("stall_mispredict", {31'd0, bif.mispredict}, 32'd0);
      advance();
    end
    drive(32'h408, 0, 32'h0, 0, 0, 0, 0, 3'd1, 1, 32'h040);
    settle();
    chk("stall_release_mispredict", {31'd0, bif.mispredict}, 32'd1);
    advance();
    chk("stall_mcnt", 32'(bif.mispredict_cnt), 32'd3);
    settle();
    chk("stall_once_mispredict", {31'd0, bif.mispredict}, 32'd0);
    advance();

    // Repeated mispredicts saturate the counter
    nmisp = 0;
    for (int i = 0; i < 200 && nmisp < 20; i++) begin
      drive(32'h200, 0, 32'h0, 0, 0, 0, 0, 3'd1, 1, 32'h080);
      settle();
      if (e_misp) nmisp++;
      advance();
    end
    chk("sat_count_reached", 32'(nmisp), 32'd20);
    chk("sat_mcnt", 32'(bif.mispredict_cnt), 32'hF);

    // Reset asserted mid-cycle while a mispredict is in EX
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (e_misp) begin
        hit = 1'b1;
        break;
      end
      advance();
    end
    chk("pre_reset_mispredict_seen", {31'd0, hit}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mispredict", {31'd0, bif.mispredict},  32'd0);
    chk("async_rst_update_en",  {31'd0, bif.update_en},   32'd0);
    chk("async_rst_mcnt",       32'(bif.mispredict_cnt),  32'd0);
    chk("async_rst_bcnt",       32'(bif.branch_cnt),      32'd0);
    model_reset();
    advance();
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      case ($urandom_range(0, 3))
        0:       npc = pc + 32'd4;
        1:       npc = $urandom & 32'hFFFF_FFFC;
        default: npc = 32'h1000 + 32'($urandom_range(0, 3) * 4);
      endcase
      case ($urandom_range(0, 3))
        0:       tgt = m_ex.tgt;
        1:       tgt = m_ex.pc + 32'd4;
        2:       tgt = 32'h1000 + 32'($urandom_range(0, 3) * 4);
        default: tgt = $urandom;
      endcase
      drive(pc, 1'($urandom_range(0, 1)), npc,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), tgt);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning width of each performance counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port PC_IF  input  32  fetch PC.
REQ-005 SHALL have port found_IF  input  1  predictor hit for PC_IF.
REQ-006 SHALL have port NPC_predicted_IF  input  32  predictor next PC.
REQ-007 SHALL have ports stall_ID, stall_EX  input  1 each  hold the IF/ID and ID/EX metadata registers.
REQ-008 SHALL have ports flush_ID, flush_EX  input  1 each  external bubble requests for the ID and EX stages.
REQ-009 SHALL have port branch_EX  input  3  branch type in EX; the `NOBRANCH code from Parameters.v means not a branch.
REQ-010 SHALL have ports br_EX  input  1 (branch taken) and branch_target_EX  input  32 (resolved target).
REQ-011 SHALL have ports found_EX, pred_taken_EX  output  1 each, and pred_target_EX, PC_EX  output  32 each: metadata of the instruction in EX.
REQ-012 SHALL have port mispredict  output  1  wrong-path fetch detected in EX.
REQ-013 SHALL have port redirect_PC  output  32  corrected fetch PC, valid when mispredict=1.
REQ-014 SHALL have ports update_en  output  1, update_PC and update_target  output  32 each, and update_taken  output  1: predictor write request.
REQ-015 SHALL have ports branch_cnt and mispredict_cnt  output  CNT_W each  performance counters.

Function
REQ-016 SHALL compute pred_taken_IF = found_IF AND (NPC_predicted_IF != PC_IF+4), with 32-bit wrap-around addition.
REQ-017 SHALL hold IF/ID metadata {valid, PC, found, pred_taken, pred_target}; each edge it loads IF values with valid=1 unless stall_ID=1, in which case it holds.
REQ-018 SHALL hold ID/EX metadata with the same fields; each edge it loads the IF/ID contents unless stall_EX=1, in which case it holds.
REQ-019 SHALL clear the valid bit of a stage register at the edge where its flush input is 1; flush takes priority over stall.
REQ-020 SHALL define adv_EX = valid_EX AND NOT stall_EX, and is_br = branch_EX != `NOBRANCH.
REQ-021 SHALL assert mispredict = adv_EX AND ((br_EX XOR pred_taken_EX) OR (br_EX AND pred_taken_EX AND branch_target_EX != pred_target_EX)).
REQ-022 SHALL assert mispredict for a non-branch (is_br=0) instruction predicted taken, since br_EX=0 for such instructions.
REQ-023 SHALL drive redirect_PC = branch_target_EX when br_EX=1, and PC_EX+4 otherwise; mispredict and redirect_PC are combinational in the cycle the instruction is in EX.
REQ-024 SHALL, at an edge with mispredict=1, clear the valid bits of both IF/ID and ID/EX, overriding stall_ID and stall_EX.
REQ-025 SHALL assert update_en = adv_EX AND (is_br OR found_EX), with update_PC=PC_EX, update_taken=br_EX AND is_br, update_target = branch_target_EX when br_EX=1 and pred_target_EX otherwise.
REQ-026 SHALL raise mispredict and update_en at most once per instruction, because a stalled EX stage suppresses both.
REQ-027 SHALL increment branch_cnt at an edge with adv_EX AND is_br.
REQ-028 SHALL increment mispredict_cnt at an edge with mispredict=1.
REQ-029 SHALL saturate both counters at all-ones with no wrap.
REQ-030 SHALL drive found_EX, pred_taken_EX, pred_target_EX and PC_EX from ID/EX regardless of its valid bit; consumers gate these outputs with mispredict or update_en.

Reset
REQ-031 SHALL, while rst=1, asynchronously clear both valid bits, all metadata fields, branch_cnt and mispredict_cnt to 0.
REQ-032 SHALL hold mispredict=0 and update_en=0 whenever rst=1, including a reset asserted while an instruction is in EX.
REQ-033 SHALL keep both stages invalid on the first edge after rst is deasserted; metadata loads normally from the following edges.

Verification
REQ-034 Predicted-taken hit: PC_IF=0x100, found_IF=1, NPC_predicted_IF=0x140, two edges, br_EX=1, branch_target_EX=0x140 -> mispredict=0, update_en=1, update_taken=1, branch_cnt=1.
REQ-035 Miss then taken: found_IF=0, PC_IF=0x200, in EX br_EX=1, target 0x080 -> mispredict=1, redirect_PC=0x080, both valid bits 0 after the edge, mispredict_cnt=1.
REQ-036 Predicted taken but not taken: pred 0x300->0x340, br_EX=0, is_br=1 -> mispredict=1, redirect_PC=0x304, update_taken=0, update_target=0x340.
REQ-037 Stall: mispredicting instruction held in EX with stall_EX=1 for 3 cycles -> mispredict=0 during the stall, then mispredict=1 for exactly one cycle; counter +1 only.
REQ-038 Saturation and reset: CNT_W=4, 20 mispredicts -> mispredict_cnt=0xF; then assert rst mid-cycle -> counters=0 and mispredict=0 immediately.
